// File: rtl/uart_hex_pkg.sv
// -----------------------------------------------------------------------------
// uart_hex_pkg
// Shared types and helpers for the UART hex value receiver.
//   rx_state_t    : byte receiver states (IDLE, START, DATA, STOP)
//   parse_state_t : line parser states (ACCUM, DISCARD)
//   ASCII_CR/LF   : line terminators
//   hex_nibble()  : ASCII byte -> {is_hex, nibble[3:0]}
// -----------------------------------------------------------------------------
package uart_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    ACCUM   = 1'b0,
    DISCARD = 1'b1
  } parse_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Returns {is_hex, nibble}. Letters a-f/A-F share the low nibble 1..6,
  // so adding 9 maps them onto 10..15.
  function automatic logic [4:0] hex_nibble(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_hex_value_rx_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART byte receiver with a 2-flop input synchronizer.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   rx         : asynchronous serial line, idles high
//   byte_valid : one-cycle pulse, byte_data holds the received byte
//   byte_data  : last received byte (LSB first on the line)
//   frame_err  : one-cycle pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx
  import uart_hex_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_byte_valid_nxt;
  logic             w_frame_err_nxt;
  logic             w_rx_s;
  logic             w_tick;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);

  // Synchronizer idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  // Data shift register carries no control meaning, so it is not reset.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_bit_nxt        = r_bit;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      START: begin
        if (w_tick) begin
          // Line high again at mid start bit: a glitch, not a frame.
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_cnt_nxt   = CNT_FULL;
            w_bit_nxt   = 3'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_cnt_nxt   = CNT_FULL;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          if (w_rx_s) begin
            w_byte_valid_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_shift;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/uart_hex_value_rx.sv
// -----------------------------------------------------------------------------
// uart_hex_value_rx
// Receives ASCII hex lines over UART and commits 1-4 digit values.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   rx          : UART line (8N1, idles high)
//   value       : last committed 16-bit value (feeds led_nibble_display)
//   value_valid : one-cycle pulse when value changes
//   frame_err   : one-cycle pulse on a low stop bit
//   parse_err   : one-cycle pulse on a bad character or a 5th digit
// -----------------------------------------------------------------------------
module uart_hex_value_rx
  import uart_hex_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        frame_err,
  output logic        parse_err
);

  logic         w_byte_valid;
  logic [7:0]   w_byte_data;
  logic         w_frame_err;
  logic [4:0]   w_hex;
  logic         w_eol;

  parse_state_t r_pstate;
  logic [15:0]  r_acc;
  logic [2:0]   r_cnt;
  logic [15:0]  r_value;
  logic         r_value_valid;
  logic         r_parse_err;
  logic         r_frame_err;

  parse_state_t w_pstate_nxt;
  logic [15:0]  w_acc_nxt;
  logic [2:0]   w_cnt_nxt;
  logic [15:0]  w_value_nxt;
  logic         w_value_valid_nxt;
  logic         w_parse_err_nxt;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  assign w_hex = hex_nibble(w_byte_data);
  assign w_eol = (w_byte_data == ASCII_CR) || (w_byte_data == ASCII_LF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate      <= ACCUM;
      r_acc         <= 16'h0000;
      r_cnt         <= 3'd0;
      r_value       <= 16'h0000;
      r_value_valid <= 1'b0;
      r_parse_err   <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_pstate      <= w_pstate_nxt;
      r_acc         <= w_acc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_value       <= w_value_nxt;
      r_value_valid <= w_value_valid_nxt;
      r_parse_err   <= w_parse_err_nxt;
      r_frame_err   <= w_frame_err;
    end
  end

  always_comb begin
    w_pstate_nxt      = r_pstate;
    w_acc_nxt         = r_acc;
    w_cnt_nxt         = r_cnt;
    w_value_nxt       = r_value;
    w_value_valid_nxt = 1'b0;
    w_parse_err_nxt   = 1'b0;

    if (w_frame_err) begin
      // A corrupted byte poisons the rest of the line.
      w_pstate_nxt = DISCARD;
    end else if (w_byte_valid) begin
      case (r_pstate)
        ACCUM: begin
          if (w_hex[4]) begin
            if (r_cnt == 3'd4) begin
              w_parse_err_nxt = 1'b1;
              w_pstate_nxt    = DISCARD;
            end else begin
              w_acc_nxt = {r_acc[11:0], w_hex[3:0]};
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end else if (w_eol) begin
            // Empty line (e.g. LF of a CRLF pair) is silently ignored.
            if (r_cnt != 3'd0) begin
              w_value_nxt       = r_acc;
              w_value_valid_nxt = 1'b1;
              w_acc_nxt         = 16'h0000;
              w_cnt_nxt         = 3'd0;
            end
          end else begin
            w_parse_err_nxt = 1'b1;
            w_pstate_nxt    = DISCARD;
          end
        end
        DISCARD: begin
          if (w_eol) begin
            w_acc_nxt    = 16'h0000;
            w_cnt_nxt    = 3'd0;
            w_pstate_nxt = ACCUM;
          end
        end
        default: w_pstate_nxt = ACCUM;
      endcase
    end
  end

  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign parse_err   = r_parse_err;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_hex_value_rx.sv
module tb_uart_hex_value_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_err;
  logic        parse_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_vv    = 0;
  int n_pe    = 0;
  int n_fe    = 0;
  logic [15:0] exp_q[$];

  uart_hex_value_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .value       (value),
    .value_valid (value_valid),
    .frame_err   (frame_err),
    .parse_err   (parse_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: each commit pops the expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (value_valid) begin
        n_vv = n_vv + 1;
        n_tests = n_tests + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_commit: value=%h, no commit expected", value);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (value !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL commit_value: got %h, expected %h", value, e);
          end
        end
      end
      if (parse_err) n_pe = n_pe + 1;
      if (frame_err) n_fe = n_fe + 1;
      if ((value_valid + parse_err + frame_err) > 1) begin
        n_tests = n_tests + 1;
        n_fail = n_fail + 1;
        $display("FAIL pulse_exclusive: vv=%b pe=%b fe=%b, at most one expected",
                 value_valid, parse_err, frame_err);
      end
    end
  end

  task automatic wait_bits(input int nbits);
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bits(1);
    end
    rx = stop;
    wait_bits(1);
    rx = 1'b1;
    wait_bits(1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    wait_bits(1);
  endtask

  task automatic check_counts(input string name, input int vv0, input int pe0,
                              input int fe0, input int dvv, input int dpe,
                              input int dfe, input logic [15:0] exp_val);
    n_tests = n_tests + 4;
    if ((n_vv - vv0) !== dvv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_vv_count: got %0d, expected %0d", name, n_vv - vv0, dvv);
    end
    if ((n_pe - pe0) !== dpe) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_pe_count: got %0d, expected %0d", name, n_pe - pe0, dpe);
    end
    if ((n_fe - fe0) !== dfe) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_fe_count: got %0d, expected %0d", name, n_fe - fe0, dfe);
    end
    if (value !== exp_val) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_value: got %h, expected %h", name, value, exp_val);
    end
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_pending: %0d expected commits missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests = n_tests + 4;
    if (value !== 16'h0000) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_value: got %h, expected 0000", name, value);
    end
    if (value_valid !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_value_valid: got %b, expected 0", name, value_valid);
    end
    if (parse_err !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_parse_err: got %b, expected 0", name, parse_err);
    end
    if (frame_err !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_frame_err: got %b, expected 0", name, frame_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_commit;
    int vv0 = n_vv, pe0 = n_pe, fe0 = n_fe;
    exp_q.push_back(16'hC931);
    send_str("C931\n");
    check_counts("commit", vv0, pe0, fe0, 1, 0, 0, 16'hC931);
  endtask

  task automatic test_crlf;
    int vv0 = n_vv, pe0 = n_pe, fe0 = n_fe;
    exp_q.push_back(16'h0012);
    send_str("12\r\n");
    check_counts("crlf", vv0, pe0, fe0, 1, 0, 0, 16'h0012);
    vv0 = n_vv;
    exp_q.push_back(16'h0ABC);
    send_str("aBc\n");
    check_counts("mixed_case", vv0, pe0, fe0, 1, 0, 0, 16'h0ABC);
  endtask

  task automatic test_overflow;
    int vv0, pe0, fe0;
    exp_q.push_back(16'hC931);
    send_str("C931\n");
    vv0 = n_vv; pe0 = n_pe; fe0 = n_fe;
    send_str("12345\n");
    check_counts("overflow", vv0, pe0, fe0, 0, 1, 0, 16'hC931);
    vv0 = n_vv; pe0 = n_pe;
    exp_q.push_back(16'h0007);
    send_str("7\n");
    check_counts("after_overflow", vv0, pe0, fe0, 1, 0, 0, 16'h0007);
  endtask

  task automatic test_bad_char;
    int vv0 = n_vv, pe0 = n_pe, fe0 = n_fe;
    send_str("1g2\n");
    check_counts("bad_char", vv0, pe0, fe0, 0, 1, 0, 16'h0007);
    pe0 = n_pe;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    wait_bits(12);
    check_counts("glitch", vv0, pe0, fe0, 0, 0, 0, 16'h0007);
  endtask

  task automatic test_frame_err;
    int vv0 = n_vv, pe0 = n_pe, fe0 = n_fe;
    send_byte(8'h41, 1'b0);
    // Idle long enough for any frame started by the low stop bit to finish.
    wait_bits(12);
    send_str("\n");
    check_counts("frame_err", vv0, pe0, fe0, 0, 0, 1, 16'h0007);
    vv0 = n_vv; fe0 = n_fe;
    exp_q.push_back(16'hFFFF);
    send_str("FFFF\n");
    check_counts("after_frame", vv0, pe0, fe0, 1, 0, 0, 16'hFFFF);
  endtask

  task automatic test_reset_mid;
    int vv0, pe0, fe0;
    logic [7:0] b;
    b = 8'h33;
    send_byte(8'h43, 1'b1);
    send_byte(8'h39, 1'b1);
    rx = 1'b0;
    wait_bits(1);
    rx = b[0];
    wait_bits(1);
    rx = b[1];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("mid_reset");
    wait_bits(2);
    check_idle_outputs("mid_reset_hold");
    rst_n = 1'b1;
    wait_bits(1);
    vv0 = n_vv; pe0 = n_pe; fe0 = n_fe;
    exp_q.push_back(16'h0005);
    send_str("5\n");
    check_counts("after_mid_reset", vv0, pe0, fe0, 1, 0, 0, 16'h0005);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_commit();
    test_crlf();
    test_overflow();
    test_bad_char();
    test_frame_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
